uart_tx_feeder: RTL and testbench

Buffers 128-bit words from a producer and hands them one at a time to the 128-bit UART top (`data_in` / `en_tx` / `u_tx_done`). It sits directly upstream of the UART transmit path.
- Decouples the producer from serial line time with a small FIFO.
- Enforces a recovery gap between successive transfers.
- Aborts a transfer that never completes, so the stream cannot hang.

---
 rtl/uart_tx_feeder.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: small word FIFO in front of the 128-bit UART transmit path.
// Hands out one word per transfer, enforces a recovery gap after each
// transfer and aborts transfers whose completion never arrives.
module uart_tx_feeder #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned GAP_CYCLES = 16,
   parameter int unsigned TIMEOUT    = 4096
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_valid,
   input  logic [127:0]             wr_data,
   output logic                     wr_ready,
   output logic [127:0]             data_in,
   output logic                     en_tx,
   input  logic                     u_tx_done,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy,
   output logic [15:0]              sent_count,
   output logic                     tx_timeout
);

   localparam int unsigned DW = 128;
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
   localparam int unsigned SW = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2
   } state_e;

   // FIFO storage and bookkeeping
   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_c;
   logic          pop_c;

   // FSM and registered outputs
   state_e        state_q, state_d;
   logic          en_tx_q, en_tx_d;
   logic [DW-1:0] data_in_q, data_in_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [SW-1:0] sent_q, sent_d;
   logic          tx_timeout_q, tx_timeout_d;

   assign wr_ready   = (count_q < CW'(DEPTH));
   assign push_c     = wr_valid & wr_ready;
   assign busy       = (state_q != S_IDLE) || (count_q != '0);
   assign fifo_count = count_q;
   assign data_in    = data_in_q;
   assign en_tx      = en_tx_q;
   assign sent_count = sent_q;
   assign tx_timeout = tx_timeout_q;

   // Next-state and output logic for the transfer sequencer
   always_comb begin
      state_d      = state_q;
      en_tx_d      = en_tx_q;
      data_in_d    = data_in_q;
      timer_d      = timer_q;
      gap_d        = gap_q;
      sent_d       = sent_q;
      tx_timeout_d = 1'b0;
      pop_c        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop_c     = 1'b1;
               data_in_d = mem_q[rd_ptr_q];
               en_tx_d   = 1'b1;
               timer_d   = '0;
               state_d   = S_SEND;
            end
         end
         S_SEND: begin
            if (u_tx_done) begin
               // completion wins over a coincident timeout
               en_tx_d = 1'b0;
               sent_d  = sent_q + SW'(1);
               gap_d   = '0;
               state_d = S_GAP;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               en_tx_d      = 1'b0;
               tx_timeout_d = 1'b1;
               gap_d        = '0;
               state_d      = S_GAP;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_GAP: begin
            // counter saturates so a sticky done simply stretches the gap
            if (gap_q == GW'(GAP_CYCLES - 1)) begin
               if (!u_tx_done) begin
                  state_d = S_IDLE;
               end
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            en_tx_d = 1'b0;
         end
      endcase
   end

   // FIFO pointer and occupancy next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_c) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_c, pop_c})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         en_tx_q      <= 1'b0;
         data_in_q    <= '0;
         timer_q      <= '0;
         gap_q        <= '0;
         sent_q       <= '0;
         tx_timeout_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         en_tx_q      <= en_tx_d;
         data_in_q    <= data_in_d;
         timer_q      <= timer_d;
         gap_q        <= gap_d;
         sent_q       <= sent_d;
         tx_timeout_q <= tx_timeout_d;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage write port; contents are don't-care while empty
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: expected words queued by the driver, checked
// by a negedge monitor against an event-level model of transfers.
module tb_uart_tx_feeder;

   localparam int unsigned DEPTH      = 4;
   localparam int unsigned GAP        = 16;
   localparam int unsigned TB_TIMEOUT = 128;
   localparam int unsigned CW         = $clog2(DEPTH) + 1;

   logic          clk       = 1'b0;
   logic          reset     = 1'b1;
   logic          wr_valid  = 1'b0;
   logic [127:0]  wr_data   = '0;
   logic          u_tx_done = 1'b0;
   logic          wr_ready;
   logic [127:0]  data_in;
   logic          en_tx;
   logic [CW-1:0] fifo_count;
   logic          busy;
   logic [15:0]   sent_count;
   logic          tx_timeout;

   int checks = 0;
   int errors = 0;
   int to_seen = 0;

   logic [127:0] exp_q[$];

   // UART responder controls: mode 0 pulses done after delay, 1 never answers
   int resp_mode  = 0;
   int resp_delay = 100;
   int resp_hold  = 1;

   uart_tx_feeder #(
      .DEPTH      (DEPTH),
      .GAP_CYCLES (GAP),
      .TIMEOUT    (TB_TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .data_in    (data_in),
      .en_tx      (en_tx),
      .u_tx_done  (u_tx_done),
      .fifo_count (fifo_count),
      .busy       (busy),
      .sent_count (sent_count),
      .tx_timeout (tx_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Holds wr_valid until accepted or the cycle budget runs out
   task automatic push(input logic [127:0] w, input int max_cyc, output bit ok);
      bit acc;
      ok       = 1'b0;
      wr_valid = 1'b1;
      wr_data  = w;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         @(negedge clk);
         acc = wr_ready;
         @(posedge clk);
         if (acc) begin
            exp_q.push_back(w);
            ok = 1'b1;
         end
         #1;
      end
      wr_valid = 1'b0;
   endtask

   task automatic push_must(input logic [127:0] w);
      bit ok;
      push(w, 400, ok);
      chk("push_accepted", 128'(ok), 128'(1));
   endtask

   task automatic wait_idle(input int max_cyc);
      bit idle_f;
      idle_f = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (!busy && !en_tx && !u_tx_done) begin
            idle_f = 1'b1;
            break;
         end
      end
      chk("wait_idle_budget", 128'(idle_f), 128'(1));
      @(posedge clk);
      #1;
   endtask

   // UART model: raises done on the resp_delay-th cycle of en_tx
   initial begin : responder
      forever begin
         @(posedge clk);
         #1;
         if (en_tx && resp_mode == 0) begin
            for (int i = 1; i < resp_delay && en_tx; i++) begin
               @(posedge clk);
               #1;
            end
            if (en_tx) begin
               u_tx_done = 1'b1;
               repeat (resp_hold) begin
                  @(posedge clk);
                  #1;
               end
               u_tx_done = 1'b0;
            end
            while (en_tx) begin
               @(posedge clk);
               #1;
            end
         end
      end
   end

   // Monitor: transfer model driven by what was presented at each edge
   initial begin : monitor
      logic [127:0] cur_word;
      logic [15:0]  exp_sent;
      bit           m_idle, m_send, exp_to, p_done, p_reset, exp_busy;
      int           hl, ge, prev_size;
      cur_word  = '0;
      exp_sent  = '0;
      m_idle    = 1'b1;
      m_send    = 1'b0;
      p_done    = 1'b0;
      p_reset   = 1'b1;
      hl        = 0;
      ge        = 0;
      prev_size = 0;
      forever begin
         @(negedge clk);
         exp_to = 1'b0;
         if (p_reset) begin
            m_idle   = 1'b1;
            m_send   = 1'b0;
            exp_sent = '0;
            cur_word = '0;
         end else if (m_send) begin
            if (p_done) begin
               m_send   = 1'b0;
               m_idle   = 1'b0;
               ge       = 0;
               exp_sent = exp_sent + 16'd1;
            end else if (hl == int'(TB_TIMEOUT)) begin
               m_send = 1'b0;
               m_idle = 1'b0;
               ge     = 0;
               exp_to = 1'b1;
            end else begin
               hl++;
            end
         end else if (!m_idle) begin
            ge++;
            if (ge >= int'(GAP) && !p_done) m_idle = 1'b1;
         end else if (prev_size != 0) begin
            if (exp_q.size() == 0) begin
               chk("pop_from_empty_model", 128'(1), 128'(0));
            end else begin
               cur_word = exp_q.pop_front();
            end
            m_send = 1'b1;
            hl     = 1;
         end
         exp_busy = m_send || !m_idle || (exp_q.size() != 0);
         chk("en_tx", 128'(en_tx), 128'(m_send));
         chk("tx_timeout", 128'(tx_timeout), 128'(exp_to));
         chk("data_in", data_in, cur_word);
         chk("sent_count", 128'(sent_count), 128'(exp_sent));
         chk("fifo_count", 128'(fifo_count), 128'(exp_q.size()));
         chk("wr_ready", 128'(wr_ready), 128'(exp_q.size() < int'(DEPTH)));
         chk("busy", 128'(busy), 128'(exp_busy));
         if (tx_timeout) to_seen++;
         p_done    = u_tx_done;
         p_reset   = reset;
         prev_size = exp_q.size();
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [127:0] burst [5];
      bit           ok;
      int           t0;
      burst[0] = 128'hffeeddccbbaa99887766554433221100;
      burst[1] = 128'h0123456789abcdef0123456789abcdef;
      burst[2] = 128'hdeadbeef_cafef00d_01234567_89abcdef;
      burst[3] = 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
      burst[4] = 128'h11111111_22222222_33333333_44444444;

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // single word, done 100 cycles after en_tx rises
      push_must(128'h00112233445566778899aabbccddeeff);
      chk("single_count_after_push", 128'(fifo_count), 128'(1));
      chk("single_en_tx_not_yet", 128'(en_tx), 128'(0));
      @(posedge clk);
      #1;
      chk("single_en_tx_rise", 128'(en_tx), 128'(1));
      chk("single_data_in", data_in, 128'h00112233445566778899aabbccddeeff);
      wait_idle(400);
      chk("single_sent", 128'(sent_count), 128'(1));
      chk("single_busy_idle", 128'(busy), 128'(0));

      // burst fill with a slow UART: five accepted, sixth held off
      resp_delay = 60;
      for (int i = 0; i < 5; i++) push_must(burst[i]);
      push(128'h66666666_66666666_66666666_66666666, 10, ok);
      chk("burst_sixth_blocked", 128'(ok), 128'(0));
      chk("burst_full_count", 128'(fifo_count), 128'(4));
      chk("burst_ready_low", 128'(wr_ready), 128'(0));
      wait_idle(2000);
      chk("burst_sent", 128'(sent_count), 128'(6));

      // timeout: UART never answers
      resp_mode = 1;
      t0 = to_seen;
      push_must({$urandom, $urandom, $urandom, $urandom});
      wait_idle(400);
      chk("timeout_pulses", 128'(to_seen - t0), 128'(1));
      chk("timeout_sent_unchanged", 128'(sent_count), 128'(6));
      chk("timeout_fifo_empty", 128'(fifo_count), 128'(0));

      // done on the last allowed cycle wins over timeout
      resp_mode  = 0;
      resp_delay = TB_TIMEOUT;
      t0 = to_seen;
      push_must({$urandom, $urandom, $urandom, $urandom});
      wait_idle(400);
      chk("coincide_no_timeout", 128'(to_seen - t0), 128'(0));
      chk("coincide_sent", 128'(sent_count), 128'(7));

      // sticky done stretches the gap before the queued second word
      resp_delay = 20;
      resp_hold  = 41;
      push_must(128'h0badf00d_0badf00d_0badf00d_0badf00d);
      push_must(128'h1337c0de_1337c0de_1337c0de_1337c0de);
      wait_idle(800);
      chk("sticky_sent", 128'(sent_count), 128'(9));
      resp_hold = 1;

      // randomized words, spacing and UART latency (some time out)
      for (int i = 0; i < 12; i++) begin
         resp_delay = $urandom_range(1, TB_TIMEOUT + 20);
         resp_hold  = $urandom_range(1, 3);
         repeat ($urandom_range(0, 5)) begin
            @(posedge clk);
            #1;
         end
         push_must({$urandom, $urandom, $urandom, $urandom});
      end
      wait_idle(6000);
      resp_hold = 1;

      // reset ten cycles into a transfer with three words queued
      resp_mode = 1;
      for (int i = 0; i < 4; i++) push_must({$urandom, $urandom, $urandom, $urandom});
      repeat (8) begin
         @(posedge clk);
         #1;
      end
      chk("pre_reset_queued", 128'(fifo_count), 128'(3));
      chk("pre_reset_sending", 128'(en_tx), 128'(1));
      reset = 1'b1;
      @(posedge clk);
      exp_q.delete();
      #1;
      reset = 1'b0;
      chk("reset_en_tx", 128'(en_tx), 128'(0));
      chk("reset_fifo_count", 128'(fifo_count), 128'(0));
      chk("reset_data_in", data_in, 128'(0));
      chk("reset_wr_ready", 128'(wr_ready), 128'(1));
      chk("reset_sent", 128'(sent_count), 128'(0));
      repeat (50) begin
         @(posedge clk);
         #1;
      end
      chk("post_reset_quiet", 128'(en_tx), 128'(0));
      chk("post_reset_busy", 128'(busy), 128'(0));

      // normal operation resumes after reset
      resp_mode  = 0;
      resp_delay = 30;
      push_must(128'hfeedface_feedface_feedface_feedface);
      wait_idle(400);
      chk("resume_sent", 128'(sent_count), 128'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
